npc_predictor: RTL and testbench
================================

NPC_PREDICTOR -- requirements
Module: npc_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, BTB entry count; power of two, range 4..1024.
REQ-002 Parameter IDX_W, default log2(ENTRIES), BTB index width.
REQ-003 Parameter CNT_W, default 2, saturating-counter width per entry, range 1..4.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port PCF  in  32  fetch-stage PC.
REQ-007 Port JalD, JalTarget  in  1/32  JAL resolved in ID and its target.
REQ-008 Port JalrE, JalrTarget  in  1/32  JALR resolved in EX and its target.
REQ-009 Port BrE  in  1  conditional branch present in EX (valid, not flushed).
REQ-010 Port BrTakenE, BranchTarget  in  1/32  actual branch outcome in EX and its taken target.
REQ-011 Port PCE  in  32  PC of the EX-stage instruction.
REQ-012 Port PredTakenE  in  1  PredTakenF value carried down the pipeline with the EX instruction.
REQ-013 Port PC_In  out  32  next PC to the PC register.
REQ-014 Port PredTakenF  out  1  fetch-stage prediction, taken = 1.
REQ-015 Port MispredE  out  1  branch misprediction in EX; pipeline flushes IF/ID on this.
REQ-016 Port BrCnt, MissCnt  out  32/32  performance counters: resolved branches, mispredictions.

Function
REQ-017 BTB SHALL be direct-mapped: ENTRIES x {valid, tag = PC[31:IDX_W+2], target[31:0], cnt[CNT_W-1:0]}, index = PC[IDX_W+1:2].
REQ-018 Lookup SHALL be combinational on PCF; hit = valid & tag match; PredTakenF = hit & cnt MSB.
REQ-019 MispredE SHALL be BrE & (PredTakenE != BrTakenE), combinational.
REQ-020 PC_In priority, highest first: JalrE -> JalrTarget; MispredE & BrTakenE -> BranchTarget; MispredE & !BrTakenE -> PCE+4; JalD -> JalTarget; PredTakenF -> BTB target; else PCF+4.
REQ-021 All PC additions SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-022 Update SHALL occur on a rising clk edge when BrE=1, rst_n=1, using the index/tag of PCE.
REQ-023 Update on hit: taken -> cnt+1 saturating at all-ones; not taken -> cnt-1 saturating at 0; target overwritten with BranchTarget when taken.
REQ-024 Update on miss: taken -> allocate (valid=1, tag, target=BranchTarget, cnt = weakly taken, MSB=1 and other bits 0); not taken -> no BTB change.
REQ-025 No read-after-write bypass: a lookup in the same cycle as an update to the same index SHALL see pre-update contents.
REQ-026 Update SHALL occur whenever BrE=1, regardless of JalrE/JalD/MispredE.
REQ-027 BrCnt SHALL increment per cycle with BrE=1; MissCnt per cycle with MispredE=1; both saturate at 0xFFFFFFFF.
REQ-028 JAL/JALR SHALL NOT be entered in the BTB.

Reset
REQ-029 While rst_n=0 at a clk edge: all valid bits cleared, all cnt set to weakly not-taken (MSB=0, other bits 1), BrCnt=MissCnt=0; no BTB update that cycle.
REQ-030 Directly after reset: PredTakenF=0; PC_In = PCF+4 absent JalD/JalrE/BrE.
REQ-031 Reset asserted mid-operation SHALL discard any pending update in that cycle; target/tag contents need not be cleared.

Verification
REQ-032 Reset, PCF=0x100 -> PC_In=0x104, PredTakenF=0, BrCnt=MissCnt=0.
REQ-033 BrE=1, BrTakenE=1, PredTakenE=0, PCE=0x200, BranchTarget=0x180 -> MispredE=1, PC_In=0x180; next cycle PCF=0x200 -> PredTakenF=1, PC_In=0x180; MissCnt=1.
REQ-034 Same branch not taken twice (PredTakenE=1 then 0) -> first MispredE=1, PC_In=0x204; afterwards cnt=0, PCF=0x200 -> PredTakenF=0.
REQ-035 Simultaneous JalrE=1 (JalrTarget=0x400), MispredE=1, JalD=1 -> PC_In=0x400; BTB update still performed.
REQ-036 Alias: ENTRIES=64, entry allocated for 0x200, PCF=0x300 (same index, different tag) -> PredTakenF=0; taken branch at 0x300 replaces the entry, and 0x200 then misses.
REQ-037 Counter saturation: four consecutive taken updates on CNT_W=2 -> cnt=3; one not-taken -> cnt=2, still predicted taken.

Source files
------------

// File: rtl/npc_predictor.sv
// ---------------------------------------------------------------------------
// npc_predictor
//   Next-PC selection with a direct-mapped BTB and per-entry saturating
//   counters for conditional branches.
//
//   Ports
//     clk, rst_n                 clock, synchronous active-low reset
//     PCF                        fetch PC (BTB lookup address)
//     JalD, JalTarget            JAL resolved in ID and its target
//     JalrE, JalrTarget          JALR resolved in EX and its target
//     BrE, BrTakenE              conditional branch in EX and its outcome
//     BranchTarget               taken target of the EX branch
//     PCE                        PC of the EX instruction (BTB update address)
//     PredTakenE                 fetch prediction carried with the EX branch
//     PC_In                      next PC for the PC register
//     PredTakenF                 fetch-stage taken prediction
//     MispredE                   EX-stage branch misprediction
//     BrCnt, MissCnt             saturating branch / mispredict counters
// ---------------------------------------------------------------------------
module npc_predictor #(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PCF,
   input  logic        JalD,
   input  logic [31:0] JalTarget,
   input  logic        JalrE,
   input  logic [31:0] JalrTarget,
   input  logic        BrE,
   input  logic        BrTakenE,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] PCE,
   input  logic        PredTakenE,
   output logic [31:0] PC_In,
   output logic        PredTakenF,
   output logic        MispredE,
   output logic [31:0] BrCnt,
   output logic [31:0] MissCnt
);

   localparam int TAG_W = 30 - IDX_W;
   // weakly not-taken = 0111.., weakly taken = 1000..
   localparam logic [CNT_W-1:0] CNT_WNT = {CNT_W{1'b1}} >> 1;
   localparam logic [CNT_W-1:0] CNT_WT  = ~CNT_WNT;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [ENTRIES-1:0]            valid;
   logic [ENTRIES-1:0][CNT_W-1:0] cnt_mem;
   logic [TAG_W-1:0]              tag_mem [ENTRIES];
   logic [31:0]                   tgt_mem [ENTRIES];

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             f_hit, e_hit;
   logic [CNT_W-1:0] e_cnt;

   // Address bits [1:0] never take part in indexing or tagging.
   logic unused_lsb;
   assign unused_lsb = ^{PCF[1:0], PCE[1:0]};

   // ---------------- lookup (fetch) ----------------
   assign f_idx      = PCF[IDX_W+1:2];
   assign f_tag      = PCF[31:IDX_W+2];
   assign f_hit      = valid[f_idx] && (tag_mem[f_idx] == f_tag);
   assign PredTakenF = f_hit && cnt_mem[f_idx][CNT_W-1];

   // ---------------- resolve (EX) ----------------
   assign e_idx    = PCE[IDX_W+1:2];
   assign e_tag    = PCE[31:IDX_W+2];
   assign e_hit    = valid[e_idx] && (tag_mem[e_idx] == e_tag);
   assign e_cnt    = cnt_mem[e_idx];
   assign MispredE = BrE && (PredTakenE != BrTakenE);

   // ---------------- next PC ----------------
   always_comb begin
      PC_In = PCF + 32'd4;
      if (JalrE)                      PC_In = JalrTarget;
      else if (MispredE && BrTakenE)  PC_In = BranchTarget;
      else if (MispredE)              PC_In = PCE + 32'd4;
      else if (JalD)                  PC_In = JalTarget;
      else if (PredTakenF)            PC_In = tgt_mem[f_idx];
   end

   // ---------------- BTB valid / counter state ----------------
   // Lookup reads these combinationally while updates land on the edge, so
   // a same-cycle lookup of the updated index sees the old contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= '0;
         cnt_mem <= {ENTRIES{CNT_WNT}};
      end else if (BrE) begin
         if (e_hit) begin
            if (BrTakenE) begin
               if (e_cnt != CNT_MAX) cnt_mem[e_idx] <= e_cnt + 1'b1;
            end else begin
               if (e_cnt != '0)      cnt_mem[e_idx] <= e_cnt - 1'b1;
            end
         end else if (BrTakenE) begin
            valid[e_idx]   <= 1'b1;
            cnt_mem[e_idx] <= CNT_WT;
         end
      end
   end

   // Tag/target are qualified by valid, so they need no reset. Any taken
   // branch (hit or allocate) writes both; on a hit the tag is unchanged.
   always_ff @(posedge clk) begin
      if (rst_n && BrE && BrTakenE) begin
         tag_mem[e_idx] <= e_tag;
         tgt_mem[e_idx] <= BranchTarget;
      end
   end

   // ---------------- performance counters ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         BrCnt   <= '0;
         MissCnt <= '0;
      end else begin
         if (BrE && (BrCnt != '1))        BrCnt   <= BrCnt + 32'd1;
         if (MispredE && (MissCnt != '1)) MissCnt <= MissCnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_npc_predictor.sv
// ---------------------------------------------------------------------------
// tb_npc_predictor
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against an entry-table reference model of the predictor.
// ---------------------------------------------------------------------------
module tb_npc_predictor;

   localparam int ENTRIES = 64;
   localparam int CNT_W   = 2;
   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int CMAX    = (1 << CNT_W) - 1;
   localparam int CHALF   = 1 << (CNT_W - 1);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] PCF = '0, JalTarget = '0, JalrTarget = '0, BranchTarget = '0, PCE = '0;
   logic        JalD = 1'b0, JalrE = 1'b0, BrE = 1'b0, BrTakenE = 1'b0, PredTakenE = 1'b0;
   logic [31:0] PC_In, BrCnt, MissCnt;
   logic        PredTakenF, MispredE;

   always #5 clk = ~clk;

   npc_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .PCF(PCF),
      .JalD(JalD), .JalTarget(JalTarget),
      .JalrE(JalrE), .JalrTarget(JalrTarget),
      .BrE(BrE), .BrTakenE(BrTakenE), .BranchTarget(BranchTarget),
      .PCE(PCE), .PredTakenE(PredTakenE),
      .PC_In(PC_In), .PredTakenF(PredTakenF), .MispredE(MispredE),
      .BrCnt(BrCnt), .MissCnt(MissCnt)
   );

   // ---------------- reference model ----------------
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   longint      m_br, m_miss;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return int'(pc >> (IDX_W + 2));
   endfunction

   // Compare all outputs with the model just before the next rising edge.
   task automatic settle();
      int          i;
      logic        ptf, mp;
      logic [31:0] pcin;
      #4;
      i   = idx_of(PCF);
      ptf = m_valid[i] && (m_tag[i] == tag_of(PCF)) && (m_cnt[i] >= CHALF);
      mp  = BrE && (PredTakenE != BrTakenE);
      if (JalrE)              pcin = JalrTarget;
      else if (mp && BrTakenE) pcin = BranchTarget;
      else if (mp)            pcin = PCE + 32'd4;
      else if (JalD)          pcin = JalTarget;
      else if (ptf)           pcin = m_tgt[i];
      else                    pcin = PCF + 32'd4;
      chk("model_PredTakenF", {31'd0, PredTakenF}, {31'd0, ptf});
      chk("model_MispredE",   {31'd0, MispredE},   {31'd0, mp});
      chk("model_PC_In",      PC_In,   pcin);
      chk("model_BrCnt",      BrCnt,   m_br[31:0]);
      chk("model_MissCnt",    MissCnt, m_miss[31:0]);
   endtask

   // Clock edge: advance the model with the inputs held across the edge.
   task automatic adv();
      int i;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0;
            m_cnt[k]   = CHALF - 1;
         end
         m_br = 0; m_miss = 0;
      end else begin
         if (BrE) begin
            i = idx_of(PCE);
            if (m_valid[i] && m_tag[i] == tag_of(PCE)) begin
               if (BrTakenE) begin
                  m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                  m_tgt[i] = BranchTarget;
               end else begin
                  m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
               end
            end else if (BrTakenE) begin
               m_valid[i] = 1;
               m_tag[i]   = tag_of(PCE);
               m_tgt[i]   = BranchTarget;
               m_cnt[i]   = CHALF;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
         end
         if (BrE && (PredTakenE != BrTakenE) && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
      #1;
   endtask

   task automatic idle();
      JalD = 0; JalrE = 0; BrE = 0; BrTakenE = 0; PredTakenE = 0;
   endtask

   task automatic br(input logic [31:0] pc, input logic tk, input logic pt, input logic [31:0] tgt);
      BrE = 1; PCE = pc; BrTakenE = tk; PredTakenE = pt; BranchTarget = tgt;
   endtask

   initial begin
      // reset
      idle(); rst_n = 0; PCF = 32'h100;
      adv(); adv();
      rst_n = 1;
      settle();
      chk("rst_PC_In", PC_In, 32'h104);
      chk("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      chk("rst_BrCnt", BrCnt, 32'd0);
      chk("rst_MissCnt", MissCnt, 32'd0);
      adv();

      // taken branch, predicted not taken -> allocate
      br(32'h200, 1, 0, 32'h180);
      settle();
      chk("alloc_Mispred", {31'd0, MispredE}, 32'd1);
      chk("alloc_PC_In", PC_In, 32'h180);
      adv();
      idle(); PCF = 32'h200;
      settle();
      chk("alloc_hit_PTF", {31'd0, PredTakenF}, 32'd1);
      chk("alloc_hit_PC_In", PC_In, 32'h180);
      chk("alloc_MissCnt", MissCnt, 32'd1);
      adv();

      // not taken twice -> counter to 0
      br(32'h200, 0, 1, 32'h180);
      settle();
      chk("nt_Mispred", {31'd0, MispredE}, 32'd1);
      chk("nt_PC_In", PC_In, 32'h204);
      adv();
      br(32'h200, 0, 0, 32'h180);
      settle();
      chk("nt2_Mispred", {31'd0, MispredE}, 32'd0);
      adv();
      idle(); PCF = 32'h200;
      settle();
      chk("nt_PTF", {31'd0, PredTakenF}, 32'd0);
      adv();

      // JALR beats mispredict and JAL; BTB update still happens
      JalrE = 1; JalrTarget = 32'h400; JalD = 1; JalTarget = 32'h500;
      br(32'h200, 1, 0, 32'h240);
      settle();
      chk("prio_PC_In", PC_In, 32'h400);
      adv();
      idle(); br(32'h200, 1, 1, 32'h240);
      adv();
      idle(); PCF = 32'h200;
      settle();
      chk("prio_upd_PTF", {31'd0, PredTakenF}, 32'd1);
      chk("prio_upd_PC_In", PC_In, 32'h240);
      adv();

      // alias: 0x300 shares the index of 0x200
      PCF = 32'h300;
      settle();
      chk("alias_PTF", {31'd0, PredTakenF}, 32'd0);
      adv();
      br(32'h300, 1, 0, 32'h380);
      adv();
      idle(); PCF = 32'h300;
      settle();
      chk("alias_new_PTF", {31'd0, PredTakenF}, 32'd1);
      chk("alias_new_PC_In", PC_In, 32'h380);
      adv();
      PCF = 32'h200;
      settle();
      chk("alias_old_PTF", {31'd0, PredTakenF}, 32'd0);
      adv();

      // saturation: 4 taken -> 3, 1 not-taken -> 2 (taken), another -> 1
      for (int k = 0; k < 4; k++) begin
         br(32'h300, 1, 1, 32'h380);
         adv();
      end
      br(32'h300, 0, 1, 32'h380);
      adv();
      idle(); PCF = 32'h300;
      settle();
      chk("sat_PTF_2", {31'd0, PredTakenF}, 32'd1);
      adv();
      br(32'h300, 0, 1, 32'h380);
      adv();
      idle(); PCF = 32'h300;
      settle();
      chk("sat_PTF_1", {31'd0, PredTakenF}, 32'd0);
      adv();

      // wrap-around of PC additions
      PCF = 32'hFFFF_FFFC;
      settle();
      chk("wrap_PCF", PC_In, 32'h0);
      adv();
      br(32'hFFFF_FFFC, 0, 1, 32'h10);
      settle();
      chk("wrap_PCE", PC_In, 32'h0);
      adv();

      // reset during a pending update discards it
      idle(); rst_n = 0; br(32'h500, 1, 0, 32'h600);
      adv();
      idle(); rst_n = 1; PCF = 32'h500;
      settle();
      chk("rst_upd_PTF", {31'd0, PredTakenF}, 32'd0);
      chk("rst_upd_BrCnt", BrCnt, 32'd0);
      adv();

      // randomized traffic over a small address pool (hits and aliases)
      for (int n = 0; n < 3000; n++) begin
         PCF          = ($urandom_range(3) << (IDX_W + 2)) | ($urandom_range(7) << 2);
         PCE          = ($urandom_range(3) << (IDX_W + 2)) | ($urandom_range(7) << 2);
         if ($urandom_range(31) == 0) PCF = 32'hFFFF_FFFC;
         JalD         = ($urandom_range(7) == 0);
         JalrE        = ($urandom_range(9) == 0);
         BrE          = $urandom_range(1);
         BrTakenE     = $urandom_range(1);
         PredTakenE   = $urandom_range(1);
         JalTarget    = $urandom;
         JalrTarget   = $urandom;
         BranchTarget = $urandom;
         rst_n        = ($urandom_range(63) != 0);
         settle();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
